load_unit: RTL

Load-side counterpart of the store byte-enable path in the MEM stage. Accepts a load from the pipeline, reads the synchronous-read data memory (one or two word accesses), and returns the aligned, sign/zero-extended result for writeback. Misaligned halfword/word loads that cross a word boundary are split into two reads. The pipeline is stalled while a load is in flight.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/load_extract.sv | 35 +++
 rtl/load_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   lsu_state_e  - load FSM states
//   F3_*         - funct3 encodings of the RV32I loads
//   is_legal_load - funct3 is one of the five supported loads
//   needs_split   - access crosses a 32-bit word boundary (low funct3 bits
//                   encode the size for both loads and stores)
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_ONE = 3'd1,
    ST_RD_LO  = 3'd2,
    ST_RD_HI  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic is_legal_load(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Halfword at offset 3 or word at any nonzero offset spills into the next word.
  function automatic logic needs_split(input logic [2:0] f3, input logic [1:0] off);
    logic split;
    split = 1'b0;
    case (f3[1:0])
      2'b01:   split = (off == 2'd3);
      2'b10:   split = (off != 2'd0);
      default: split = 1'b0;
    endcase
    return split;
  endfunction

endpackage

// File: rtl/load_extract.sv
// load_extract: combinational alignment and extension of load data.
//   hi, lo  - the two memory words ({hi,lo}; hi is 0 for single-word loads)
//   offset  - byte offset of the load within lo
//   funct3  - load type
//   result  - aligned, sign/zero-extended 32-bit load result
module load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [63:0] both;
  logic [63:0] shifted;
  logic [31:0] win;

  assign both    = {hi, lo};
  assign shifted = both >> {offset, 3'b000};
  assign win     = shifted[31:0];

  always_comb begin
    result = win;
    case (funct3)
      F3_LB:   result = {{24{win[7]}}, win[7:0]};
      F3_LBU:  result = {24'd0, win[7:0]};
      F3_LH:   result = {{16{win[15]}}, win[15:0]};
      F3_LHU:  result = {16'd0, win[15:0]};
      default: result = win;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// load_unit: MEM-stage load engine over a synchronous-read word memory.
//   clk, rst_n   - clock, asynchronous active-low reset
//   MemReadM     - load request, held stable while StallLsuM=1
//   funct3M      - load type; ALUResultM - byte address
//   FlushM       - kills the in-flight load (wins over everything)
//   MemReM/MemAddrM - memory read enable / word address; MemRdataM arrives next cycle
//   StallLsuM    - holds IF/ID/EX/MEM while a load is in flight
//   LoadDataW/LoadValidW - registered result and its one-cycle valid pulse
//
// Handshake: a request is taken in IDLE when MemReadM=1, funct3 is legal and
// FlushM=0; StallLsuM then stays high until the RESP cycle, in which
// LoadValidW pulses and the pipeline is released (the request still visible
// in RESP is the same instruction and is not re-accepted).
module load_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic        FlushM,
  output logic        MemReM,
  output logic [29:0] MemAddrM,
  input  logic [31:0] MemRdataM,
  output logic        StallLsuM,
  output logic [31:0] LoadDataW,
  output logic        LoadValidW
);

  lsu_state_e  state;
  logic [2:0]  cap_f3;
  logic [1:0]  cap_off;
  logic [29:0] cap_waddr;
  logic [31:0] lo_word;
  logic        valid_q;

  logic        accept;
  logic        hi_issue;
  logic [31:0] ext_hi;
  logic [31:0] ext_lo;
  logic [31:0] ext_result;

  // rst_n gating keeps the memory quiet while reset is asserted even if the
  // pipeline is presenting a request.
  assign accept   = rst_n && (state == ST_IDLE) && MemReadM &&
                    is_legal_load(funct3M) && !FlushM;
  assign hi_issue = (state == ST_RD_LO) && !FlushM;

  assign MemReM   = accept || hi_issue;
  assign MemAddrM = accept   ? ALUResultM[31:2] :
                    hi_issue ? cap_waddr + 30'd1 : 30'd0;

  always_comb begin
    StallLsuM = 1'b0;
    case (state)
      ST_IDLE:                        StallLsuM = accept;
      ST_RD_ONE, ST_RD_LO, ST_RD_HI:  StallLsuM = 1'b1;
      default:                        StallLsuM = 1'b0;
    endcase
  end

  // A flush arriving in the RESP cycle still suppresses the pulse.
  assign LoadValidW = valid_q && !FlushM;

  // The word arriving now is hi only in RD_HI; otherwise it is lo with hi=0.
  assign ext_lo = (state == ST_RD_HI) ? lo_word   : MemRdataM;
  assign ext_hi = (state == ST_RD_HI) ? MemRdataM : 32'd0;

  load_extract u_extract (
    .hi     (ext_hi),
    .lo     (ext_lo),
    .offset (cap_off),
    .funct3 (cap_f3),
    .result (ext_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cap_f3    <= 3'd0;
      cap_off   <= 2'd0;
      cap_waddr <= 30'd0;
      lo_word   <= 32'd0;
      valid_q   <= 1'b0;
      LoadDataW <= 32'd0;
    end else begin
      valid_q <= 1'b0;
      if (FlushM && (state != ST_IDLE)) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              cap_f3    <= funct3M;
              cap_off   <= ALUResultM[1:0];
              cap_waddr <= ALUResultM[31:2];
              state     <= needs_split(funct3M, ALUResultM[1:0]) ? ST_RD_LO : ST_RD_ONE;
            end
          end
          ST_RD_ONE: begin
            LoadDataW <= ext_result;
            valid_q   <= 1'b1;
            state     <= ST_RESP;
          end
          ST_RD_LO: begin
            lo_word <= MemRdataM;
            state   <= ST_RD_HI;
          end
          ST_RD_HI: begin
            LoadDataW <= ext_result;
            valid_q   <= 1'b1;
            state     <= ST_RESP;
          end
          ST_RESP: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
